// File: rtl/keypad_scanner.sv
// Row-scanning keypad controller: synchronizes column senses, debounces press and release,
// and reports one key code per accepted press. Define KEYPAD_AUTOREPEAT_EN for held-key auto-repeat.
//
// state          | meaning
// ---------------+---------------------------------------------------------------
// ST_SCAN        | rows driven in turn, SCAN_CYCLES each, looking for any column
// ST_DEB_PRESS   | row frozen, latched column must stay high DEBOUNCE_CYCLES
// ST_HELD        | key accepted, waiting for the latched column to drop
// ST_DEB_RELEASE | latched column must stay low DEBOUNCE_CYCLES before rescanning
module keypad_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_CYCLES   = 250000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [COLS-1:0]               col_i,
    output logic [ROWS-1:0]               row_o,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    output logic                          key_valid,
    output logic                          key_held
);

    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int CODE_W = $clog2(ROWS*COLS);
    localparam int SCAN_W = $clog2(SCAN_CYCLES);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS-1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES-1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES-1);

    if (ROWS < 2 || ROWS > 16 || COLS < 2 || COLS > 16 || SCAN_CYCLES < 4 ||
        DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEB_PRESS,
        ST_HELD,
        ST_DEB_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [COLS-1:0]     sync1_q, cols_q;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d;
    logic [COL_W-1:0]    low_col;
    logic [ROW_W-1:0]    next_row;
    logic                col_hit;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES-1);
    logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
`endif

    // Scanning high-to-low leaves the lowest set column as the winner.
    always_comb begin
        low_col = '0;
        for (int c = COLS-1; c >= 0; c--) begin
            if (cols_q[c]) low_col = COL_W'(c);
        end
    end

    assign next_row = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
    assign col_hit  = cols_q[col_q];

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        code_d     = code_q;
        valid_d    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d  = rep_cnt_q;
`endif
        case (state_q)
            ST_SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (|cols_q) begin
                        col_d     = low_col;
                        deb_cnt_d = '0;
                        state_d   = ST_DEB_PRESS;
                    end else begin
                        row_d = next_row;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            ST_DEB_PRESS: begin
                if (!col_hit) begin
                    row_d      = next_row;
                    scan_cnt_d = '0;
                    deb_cnt_d  = '0;
                    state_d    = ST_SCAN;
                end else if (deb_cnt_q == DEB_LAST) begin
                    code_d    = CODE_W'(row_q) * CODE_W'(COLS) + CODE_W'(col_q);
                    valid_d   = 1'b1;
                    deb_cnt_d = '0;
                    state_d   = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_cnt_d = '0;
`endif
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            ST_HELD: begin
                if (!col_hit) begin
                    deb_cnt_d = '0;
                    state_d   = ST_DEB_RELEASE;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (rep_cnt_q == REP_LAST) begin
                    valid_d   = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
`endif
            end
            ST_DEB_RELEASE: begin
                // Repeat count is left untouched here so a bounce resumes it.
                if (col_hit) begin
                    deb_cnt_d = '0;
                    state_d   = ST_HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    row_d      = '0;
                    scan_cnt_d = '0;
                    deb_cnt_d  = '0;
                    state_d    = ST_SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_SCAN;
            sync1_q    <= '0;
            cols_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= col_i;
            cols_q     <= sync1_q;
            row_q      <= row_d;
            col_q      <= col_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q  <= rep_cnt_d;
`endif
        end
    end

    assign row_o     = ROWS'(1) << row_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = (state_q == ST_HELD) || (state_q == ST_DEB_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboarded bench for keypad_scanner: a key-matrix model closes columns onto driven rows,
// expected codes are queued at press time and matched by a monitor on every key_valid pulse.
module tb_keypad_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 3;
    localparam int SCAN = 4;
    localparam int DEB  = 8;
    localparam int REP  = 32;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int EXP_PULSES_100 = 4;
`else
    localparam int EXP_PULSES_100 = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [COLS-1:0] col_i;
    logic [ROWS-1:0] row_o;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_held;

    logic [COLS-1:0] mat [ROWS];

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int last_code = -1;
    int mon_code;
    logic prev_held = 1'b0;

    int r_row, r_mask, r_long, n_pulse, p0, ok;

    always #5 clk = ~clk;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(SCAN),
        .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .col_i(col_i), .row_o(row_o),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    // A pressed key connects its column to whichever of its rows is being driven.
    always_comb begin
        col_i = '0;
        for (int r = 0; r < ROWS; r++)
            if (row_o[r]) col_i = col_i | mat[r];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int lowest_col(input int m);
        for (int c = 0; c < COLS; c++)
            if (m[c]) return c;
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_row(input int r, input int bound, input string name);
        int k = 0;
        while (row_o != (4'b0001 << r) && k < bound) begin
            tick(1);
            k++;
        end
        check(name, row_o, 4'b0001 << r);
    endtask

    task automatic wait_held(input logic v, input int bound, input string name);
        int k = 0;
        while (key_held != v && k < bound) begin
            tick(1);
            k++;
        end
        check(name, key_held, v);
    endtask

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            if (prev_held) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                check("repeat_code", key_code, last_code);
`else
                check("extra_pulse", key_valid, 0);
`endif
            end else if (exp_q.size() == 0) begin
                check("spurious_pulse", key_valid, 0);
            end else begin
                mon_code = exp_q.pop_front();
                check("key_code", key_code, mon_code);
                last_code = mon_code;
            end
        end
        prev_held = key_held;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < ROWS; r++) mat[r] = '0;
        rst_n = 1'b0;
        tick(3);
        check("rst_row", row_o, 1);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_code", key_code, 0);

        rst_n = 1'b1;
        check("scan_row0", row_o, 1);
        for (int i = 1; i <= 4; i++) begin
            tick(SCAN);
            check("scan_seq", row_o, 1 << (i % ROWS));
        end

        // Key at row 1 col 0 held 30 cycles.
        wait_row(1, 20, "find_row1");
        mat[1] = 3'b001;
        exp_q.push_back(1 * COLS + 0);
        tick(30);
        check("held_r1", key_held, 1);
        check("accepted_r1", exp_q.size(), 0);
        mat[1] = '0;
        wait_held(1'b0, 20, "release_r1");
        check("rescan_r1", row_o, 1);

        // Short bounce on row 3: no acceptance, scan continues at row 0.
        wait_row(3, 20, "find_row3");
        mat[3] = 3'b010;
        tick(5);
        mat[3] = '0;
        wait_row(0, 20, "rescan_short");
        tick(8);
        check("short_no_held", key_held, 0);

        // Two columns in row 2: lowest column wins; release glitch keeps the key held.
        wait_row(2, 20, "find_row2");
        mat[2] = 3'b110;
        exp_q.push_back(2 * COLS + 1);
        tick(30);
        check("held_r2", key_held, 1);
        check("code_r2", key_code, 7);
        mat[2] = '0;
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (!key_held) ok = 0;
        end
        mat[2] = 3'b110;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!key_held) ok = 0;
        end
        check("glitch_held", ok, 1);
        mat[2] = '0;
        wait_held(1'b0, 20, "release_r2");

        // Reset in the middle of press debounce.
        wait_row(0, 20, "find_row0");
        mat[0] = 3'b001;
        tick(6);
        rst_n = 1'b0;
        tick(2);
        check("mid_rst_row", row_o, 1);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_held", key_held, 0);
        check("mid_rst_code", key_code, 0);
        mat[0] = '0;
        tick(1);
        rst_n = 1'b1;
        tick(SCAN);
        check("post_rst_row1", row_o, 2);
        check("post_rst_held", key_held, 0);

        // Key 0 held for 100 cycles past acceptance.
        wait_row(0, 20, "find_row0b");
        mat[0] = 3'b001;
        exp_q.push_back(0);
        wait_held(1'b1, 40, "accept_k0");
        check("valid_at_accept", key_valid, 1);
        n_pulse = 0;
        for (int i = 0; i < 100; i++) begin
            if (key_valid) n_pulse++;
            tick(1);
        end
        check("pulses_100", n_pulse, EXP_PULSES_100);
        check("code_k0", key_code, 0);
        mat[0] = '0;
        wait_held(1'b0, 20, "release_k0");

        // Randomized single-row presses, long (accepted) or short (rejected).
        for (int it = 0; it < 12; it++) begin
            r_row  = $urandom_range(ROWS-1, 0);
            r_mask = $urandom_range(7, 1);
            r_long = $urandom_range(1, 0);
            tick($urandom_range(5, 0));
            mat[r_row] = r_mask[COLS-1:0];
            if (r_long != 0) begin
                exp_q.push_back(r_row * COLS + lowest_col(r_mask));
                tick($urandom_range(60, 40));
                check("rand_accept", exp_q.size(), 0);
                check("rand_held", key_held, 1);
                mat[r_row] = '0;
                wait_held(1'b0, 30, "rand_release");
            end else begin
                tick($urandom_range(6, 1));
                mat[r_row] = '0;
                tick(20);
                check("rand_short_held", key_held, 0);
            end
        end

        tick(5);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, giving the number of keypad rows (2..16).
REQ-002 The block SHALL have parameter COLS, default 3, giving the number of keypad columns (2..16).
REQ-003 The block SHALL have parameter SCAN_CYCLES, default 1000, giving the clock cycles each row is driven per scan slot (>=4).
REQ-004 The block SHALL have parameter DEBOUNCE_CYCLES, default 20000, giving the stable cycles required for press and for release (>=2).
REQ-005 The block SHALL have parameter REPEAT_CYCLES, default 250000, giving the auto-repeat period (used only with KEYPAD_AUTOREPEAT_EN).
REQ-006 clk  in  1  sole clock; all logic rising-edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 col_i  in  COLS  column sense lines, active-high, asynchronous to clk.
REQ-009 row_o  out  ROWS  row drive, one-hot active-high.
REQ-010 key_code  out  $clog2(ROWS*COLS)  index of the accepted key = row*COLS + col.
REQ-011 key_valid  out  1  one-cycle pulse when key_code is newly accepted.
REQ-012 key_held  out  1  high while the accepted key remains pressed.

Function
REQ-013 col_i SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value colS.
REQ-014 The FSM SHALL have the states SCAN, DEB_PRESS, HELD and DEB_RELEASE.
REQ-015 In SCAN, row_o SHALL advance row 0..ROWS-1 every SCAN_CYCLES cycles, wrapping from ROWS-1 to 0.
REQ-016 On the last cycle of a row slot, if colS != 0, the FSM SHALL latch the row and the lowest-index set column, freeze row_o, and enter DEB_PRESS.
REQ-017 In DEB_PRESS, if colS bit[latched col] stays 1 for DEBOUNCE_CYCLES consecutive cycles, the FSM SHALL enter HELD; any 0 SHALL return it to SCAN at the next row without a pulse.
REQ-018 On entry to HELD, the block SHALL update key_code and pulse key_valid for exactly one cycle, then assert key_held.
REQ-019 In HELD, colS bit[latched col] == 0 SHALL cause entry to DEB_RELEASE; other columns SHALL be ignored, with no second key and no rollover.
REQ-020 In DEB_RELEASE, DEBOUNCE_CYCLES consecutive zeros SHALL deassert key_held and return the FSM to SCAN at row 0; any 1 SHALL return it to HELD with no new pulse.
REQ-021 key_code SHALL hold its last value until the next acceptance.
REQ-022 Simultaneous presses in one row SHALL resolve to the lowest column; presses in different rows SHALL resolve to the first row scanned.
REQ-023 Counters SHALL saturate and never wrap inside a state; the row index SHALL wrap only per REQ-015.

Reset
REQ-024 While rst_n == 0 at a clock edge, the FSM SHALL enter SCAN with row_o = 1 (row 0), key_code = 0, key_valid = 0, key_held = 0, all counters 0 and the synchronizer 0.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abort without a key_valid pulse; after release, scanning SHALL restart at row 0.

Configuration
REQ-026 With KEYPAD_AUTOREPEAT_EN defined, while in HELD the block SHALL re-pulse key_valid (same key_code) every REPEAT_CYCLES cycles after the initial pulse; DEB_RELEASE SHALL pause the repeat count and a return to HELD SHALL resume it.
REQ-027 Without KEYPAD_AUTOREPEAT_EN, the block SHALL emit exactly one key_valid per accepted press and SHALL compile no repeat counter.

Verification (ROWS=4, COLS=3, SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32)
REQ-028 Reset -> row_o=0001, key_valid=0, key_held=0, key_code=0; row_o sequence 0001,0010,0100,1000,0001 at 4-cycle steps.
REQ-029 Hold col_i=001 while row 1 is driven, stable for 30 cycles -> single key_valid with key_code=3, key_held=1; release col_i -> key_held=0 after 8 zero cycles, scan resumes at row 0.
REQ-030 Apply col_i=010 on row 3 for 5 cycles, then 0 -> no key_valid, scan resumes.
REQ-031 Apply col_i=110 on row 2 -> key_code=7 (col 1 wins); a 3-cycle release glitch in HELD -> no new pulse, key_held stays 1.
REQ-032 Assert rst_n=0 during DEB_PRESS -> no pulse, outputs at reset values.
REQ-033 With KEYPAD_AUTOREPEAT_EN and key 0 held 100 cycles past acceptance -> key_valid pulses at +0, +32, +64, +96, all key_code=0; without the macro -> one pulse.
